// File: rtl/nx_stream_unpack.sv
// rtl/nx_stream_unpack.sv - splits wide AXI4-stream beats into ordered narrow mesh messages
// Optional zero-slot skipping is compiled in with NX_UNPACK_SKIP_EMPTY_EN.
module nx_stream_unpack #(
    parameter int AXI4_DATA_WIDTH = 128,
    parameter int MSG_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [AXI4_DATA_WIDTH-1:0] inbound_tdata,
    input  logic                       inbound_tlast,
    input  logic                       inbound_tvalid,
    output logic                       inbound_tready,
    output logic [MSG_WIDTH-1:0]       msg_data,
    output logic                       msg_last,
    output logic                       msg_valid,
    input  logic                       msg_ready,
    output logic                       idle
);

    localparam int SLOTS = AXI4_DATA_WIDTH / MSG_WIDTH;
    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic {
        EMPTY,
        DRAIN
    } state_t;

    state_t                     state_q, state_d;
    logic [AXI4_DATA_WIDTH-1:0] hold_data_q;
    logic                       hold_last_q;
    logic                       running_q;
    logic [IDX_W-1:0]           slot_q, slot_d;
    logic [SLOTS-1:0]           pend_q, pend_d;
    logic [SLOTS-1:0]           in_mask;
    logic [SLOTS-1:0]           pend_left;
    logic                       is_final;
    logic                       accept_beat;
    logic                       msg_fire;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [SLOTS-1:0] m);
        lowest_set = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (m[k]) lowest_set = IDX_W'(k);
        end
    endfunction

    // Slots still owed for the held beat; the final slot is the one that empties this mask.
    always_comb begin
        in_mask = '0;
`ifdef NX_UNPACK_SKIP_EMPTY_EN
        for (int k = 0; k < SLOTS; k++) begin
            in_mask[k] = |inbound_tdata[k*MSG_WIDTH +: MSG_WIDTH];
        end
        if (in_mask == '0 && inbound_tlast) in_mask[0] = 1'b1;
`else
        in_mask = '1;
`endif
    end

    assign pend_left   = pend_q & ~(SLOTS'(1) << slot_q);
    assign is_final    = (pend_left == '0);
    assign msg_valid   = (state_q == DRAIN);
    assign msg_last    = msg_valid && is_final && hold_last_q;
    assign msg_data    = msg_valid ? hold_data_q[slot_q*MSG_WIDTH +: MSG_WIDTH] : '0;
    assign idle        = (state_q == EMPTY) && !msg_valid;
    // running_q keeps tready low through reset and until the first edge after release.
    assign inbound_tready = running_q &&
                            ((state_q == EMPTY) || (is_final && msg_valid && msg_ready));
    assign accept_beat = inbound_tvalid && inbound_tready;
    assign msg_fire    = msg_valid && msg_ready;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        pend_d  = pend_q;
        if (accept_beat) begin
            pend_d  = in_mask;
            slot_d  = lowest_set(in_mask);
            state_d = (in_mask != '0) ? DRAIN : EMPTY;
        end else if (msg_fire) begin
            pend_d = pend_left;
            slot_d = lowest_set(pend_left);
            if (is_final) state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= EMPTY;
            slot_q      <= '0;
            pend_q      <= '0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            pend_q    <= pend_d;
            running_q <= 1'b1;
            if (accept_beat) begin
                hold_data_q <= inbound_tdata;
                hold_last_q <= inbound_tlast;
            end
        end
    end

endmodule

// File: tb/tb_nx_stream_unpack.sv
// tb/tb_nx_stream_unpack.sv - directed self-checking bench for nx_stream_unpack
module tb_nx_stream_unpack;

    logic         clk = 1'b0;
    logic         rstn;
    logic [127:0] inbound_tdata;
    logic         inbound_tlast;
    logic         inbound_tvalid;
    logic         inbound_tready;
    logic [31:0]  msg_data;
    logic         msg_last;
    logic         msg_valid;
    logic         msg_ready;
    logic         idle;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nx_stream_unpack #(.AXI4_DATA_WIDTH(128), .MSG_WIDTH(32)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .inbound_tdata  (inbound_tdata),
        .inbound_tlast  (inbound_tlast),
        .inbound_tvalid (inbound_tvalid),
        .inbound_tready (inbound_tready),
        .msg_data       (msg_data),
        .msg_last       (msg_last),
        .msg_valid      (msg_valid),
        .msg_ready      (msg_ready),
        .idle           (idle)
    );

    task automatic test_reset();
        rstn = 1'b0;
        inbound_tdata = '0;
        inbound_tlast = 1'b0;
        inbound_tvalid = 1'b0;
        msg_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({inbound_tready, msg_valid, msg_last, msg_data, idle} !== {1'b0, 1'b0, 1'b0, 32'h0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: got tready=%b valid=%b last=%b data=%h idle=%b, expected 0 0 0 0 1",
                     inbound_tready, msg_valid, msg_last, msg_data, idle);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (inbound_tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_tready: got %b expected 1", inbound_tready);
        end
    endtask

    task automatic test_single_beat();
        inbound_tdata = {32'h4, 32'h3, 32'h2, 32'h1};
        inbound_tlast = 1'b1;
        inbound_tvalid = 1'b1;
        msg_ready = 1'b1;
        checks++;
        if (inbound_tready !== 1'b1) begin
            failures++;
            $display("FAIL single_accept: tready got %b expected 1", inbound_tready);
        end
        @(negedge clk);
        inbound_tvalid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if ({msg_valid, msg_last, msg_data} !== {1'b1, (i == 4), 32'(i)}) begin
                failures++;
                $display("FAIL single_msg%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                         i, msg_valid, msg_last, msg_data, (i == 4), 32'(i));
            end
            @(negedge clk);
        end
        checks++;
        if ({idle, msg_valid} !== 2'b10) begin
            failures++;
            $display("FAIL single_idle: got idle=%b valid=%b expected idle=1 valid=0", idle, msg_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [8];
        exp_d = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h21, 32'h22, 32'h23, 32'h24};
        inbound_tdata = {32'h14, 32'h13, 32'h12, 32'h11};
        inbound_tlast = 1'b0;
        inbound_tvalid = 1'b1;
        msg_ready = 1'b1;
        @(negedge clk);
        inbound_tdata = {32'h24, 32'h23, 32'h22, 32'h21};
        inbound_tlast = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) inbound_tvalid = 1'b0;
            checks++;
            if ({msg_valid, msg_last, msg_data, inbound_tready} !==
                {1'b1, (i == 7), exp_d[i], (i == 3 || i == 7)}) begin
                failures++;
                $display("FAIL b2b_msg%0d: got v=%b l=%b d=%h tready=%b expected v=1 l=%b d=%h tready=%b",
                         i, msg_valid, msg_last, msg_data, inbound_tready, (i == 7), exp_d[i], (i == 3 || i == 7));
            end
            @(negedge clk);
        end
        checks++;
        if ({idle, msg_valid} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_idle: got idle=%b valid=%b expected idle=1 valid=0", idle, msg_valid);
        end
    endtask

    task automatic test_backpressure();
        inbound_tdata = {32'h4, 32'h3, 32'h2, 32'h1};
        inbound_tlast = 1'b0;
        inbound_tvalid = 1'b1;
        msg_ready = 1'b1;
        @(negedge clk);
        inbound_tvalid = 1'b0;
        checks++;
        if (msg_data !== 32'h1) begin
            failures++;
            $display("FAIL bp_slot0: got %h expected 00000001", msg_data);
        end
        @(negedge clk);
        msg_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({msg_valid, msg_last, msg_data, inbound_tready} !== {1'b1, 1'b0, 32'h2, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold%0d: got v=%b l=%b d=%h tready=%b expected v=1 l=0 d=00000002 tready=0",
                         i, msg_valid, msg_last, msg_data, inbound_tready);
            end
            @(negedge clk);
        end
        msg_ready = 1'b1;
        checks++;
        if (msg_data !== 32'h2) begin
            failures++;
            $display("FAIL bp_release: got %h expected 00000002", msg_data);
        end
        @(negedge clk);
        checks++;
        if ({msg_valid, msg_data} !== {1'b1, 32'h3}) begin
            failures++;
            $display("FAIL bp_slot2: got v=%b d=%h expected v=1 d=00000003", msg_valid, msg_data);
        end
        @(negedge clk);
        checks++;
        if ({msg_valid, msg_last, msg_data} !== {1'b1, 1'b0, 32'h4}) begin
            failures++;
            $display("FAIL bp_slot3: got v=%b l=%b d=%h expected v=1 l=0 d=00000004", msg_valid, msg_last, msg_data);
        end
        @(negedge clk);
        checks++;
        if (idle !== 1'b1) begin
            failures++;
            $display("FAIL bp_idle: got %b expected 1", idle);
        end
    endtask

    task automatic test_reset_mid();
        inbound_tdata = {32'hD, 32'hC, 32'hB, 32'hA};
        inbound_tlast = 1'b1;
        inbound_tvalid = 1'b1;
        msg_ready = 1'b1;
        @(negedge clk);
        inbound_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({msg_valid, msg_data} !== {1'b1, 32'hC}) begin
            failures++;
            $display("FAIL rst_mid_slot2: got v=%b d=%h expected v=1 d=0000000c", msg_valid, msg_data);
        end
        #1 rstn = 1'b0;
        #1;
        checks++;
        if ({msg_valid, idle, inbound_tready} !== 3'b010) begin
            failures++;
            $display("FAIL rst_mid_async: got v=%b idle=%b tready=%b expected v=0 idle=1 tready=0",
                     msg_valid, idle, inbound_tready);
        end
        @(negedge clk);
        rstn = 1'b1;
        checks++;
        if (inbound_tready !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_tready_pre_edge: got %b expected 0", inbound_tready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({msg_valid, idle, inbound_tready} !== 3'b011) begin
                failures++;
                $display("FAIL rst_mid_after%0d: got v=%b idle=%b tready=%b expected v=0 idle=1 tready=1",
                         i, msg_valid, idle, inbound_tready);
            end
        end
    endtask

`ifdef NX_UNPACK_SKIP_EMPTY_EN
    task automatic test_skip_empty();
        inbound_tdata = {32'h0, 32'h7, 32'h0, 32'h5};
        inbound_tlast = 1'b1;
        inbound_tvalid = 1'b1;
        msg_ready = 1'b1;
        @(negedge clk);
        inbound_tvalid = 1'b0;
        checks++;
        if ({msg_valid, msg_last, msg_data} !== {1'b1, 1'b0, 32'h5}) begin
            failures++;
            $display("FAIL skip_first: got v=%b l=%b d=%h expected v=1 l=0 d=00000005", msg_valid, msg_last, msg_data);
        end
        @(negedge clk);
        checks++;
        if ({msg_valid, msg_last, msg_data} !== {1'b1, 1'b1, 32'h7}) begin
            failures++;
            $display("FAIL skip_second: got v=%b l=%b d=%h expected v=1 l=1 d=00000007", msg_valid, msg_last, msg_data);
        end
        @(negedge clk);
        inbound_tdata = '0;
        inbound_tlast = 1'b0;
        inbound_tvalid = 1'b1;
        @(negedge clk);
        inbound_tvalid = 1'b0;
        checks++;
        if ({msg_valid, inbound_tready} !== 2'b01) begin
            failures++;
            $display("FAIL skip_zero_nolast: got v=%b tready=%b expected v=0 tready=1", msg_valid, inbound_tready);
        end
        inbound_tlast = 1'b1;
        inbound_tvalid = 1'b1;
        @(negedge clk);
        inbound_tvalid = 1'b0;
        checks++;
        if ({msg_valid, msg_last, msg_data} !== {1'b1, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL skip_zero_last: got v=%b l=%b d=%h expected v=1 l=1 d=00000000", msg_valid, msg_last, msg_data);
        end
        @(negedge clk);
        checks++;
        if ({msg_valid, idle} !== 2'b01) begin
            failures++;
            $display("FAIL skip_zero_last_done: got v=%b idle=%b expected v=0 idle=1", msg_valid, idle);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef NX_UNPACK_SKIP_EMPTY_EN
        test_skip_empty();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
